// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C burst reader: FSM encoding, sensor address,
// default burst limit and the burst-length clamp helper.
// Optional watchdog feature in the top level is enabled by I2C_BURST_TIMEOUT_EN.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WR_PTR    = 3'd1,
        ST_RD_REQ    = 3'd2,
        ST_RD_LAST   = 3'd3,
        ST_WAIT_STOP = 3'd4,
        ST_FINISH    = 3'd5
    } state_t;

    // 7-bit sensor address as seen by the I2C master.
    localparam logic [7:0] DEVICE_ADDRESS    = 8'h68;
    localparam int         MAX_BYTES_DEFAULT = 8;
    localparam int         WDOG_W            = 16;

    // A request of 0 bytes still reads one; anything past the limit is cut to it.
    function automatic logic [3:0] clamp_count(input logic [3:0] req, input int max_bytes);
        if (req == 4'd0) begin
            return 4'd1;
        end
        if (int'(req) > max_bytes) begin
            return 4'(max_bytes);
        end
        return req;
    endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Free-running divider producing a one-cycle tick every CLK_DIV system clocks.
// The tick is high while the count is 0 and is held low during reset.
module i2c_tick_gen #(
    parameter int CLK_DIV = 250
) (
    input  logic clk,
    input  logic sync_reset_i,
    output logic tick_o
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: wrap at CLK_DIV-1.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(CLK_DIV - 1)) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (sync_reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == '0) && !sync_reset_i;

endmodule

// File: rtl/i2c_burst_reader.sv
// Burst register reader in front of a byte-level I2C master: writes the
// register pointer, then issues byte_count reads, dropping the read request
// before the last byte so the master NACKs it, and streams bytes out.
// Define I2C_BURST_TIMEOUT_EN to add a 16-bit watchdog that aborts a stuck burst.
module i2c_burst_reader
    import i2c_pkg::*;
#(
    parameter int CLK_DIV   = 250,
    parameter int MAX_BYTES = MAX_BYTES_DEFAULT
) (
    input  logic       clk,
    input  logic       sync_reset,
    input  logic       start,
    input  logic [7:0] reg_addr,
    input  logic [3:0] byte_count,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [7:0] rd_data,
    output logic [2:0] rd_index,
    output logic       rd_valid,
    output logic       internal_clk,
    output logic [7:0] m_data_in,
    output logic       m_write_enable,
    output logic       m_read_enable,
    output logic       m_sync_reset,
    input  logic       m_queued,
    input  logic       m_data_valid,
    input  logic       m_nack,
    input  logic       m_stop,
    input  logic [7:0] m_data_out
);

    state_t     state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic [3:0] count_q, count_d;
    logic [3:0] q_cnt_q, q_cnt_d;
    logic [2:0] byte_cnt_q, byte_cnt_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic [2:0] rd_index_q, rd_index_d;
    logic       rd_valid_q, rd_valid_d;
    logic       error_q, error_d;
    logic       timeout_hit;
    logic       in_burst;

    assign in_burst = (state_q == ST_WR_PTR) || (state_q == ST_RD_REQ) ||
                      (state_q == ST_RD_LAST) || (state_q == ST_WAIT_STOP);

    i2c_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk         (clk),
        .sync_reset_i(sync_reset),
        .tick_o      (internal_clk)
    );

`ifdef I2C_BURST_TIMEOUT_EN
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              abort_q;

    // Watchdog: counts cycles spent inside a burst, saturating at all-ones.
    always_comb begin
        wdog_d = '0;
        if (in_burst) begin
            wdog_d = (wdog_q == {WDOG_W{1'b1}}) ? wdog_q : wdog_q + 1'b1;
        end
    end

    assign timeout_hit = in_burst && (wdog_q == {WDOG_W{1'b1}});

    // Watchdog register and one-cycle master abort pulse.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            wdog_q  <= '0;
            abort_q <= 1'b0;
        end else begin
            wdog_q  <= wdog_d;
            abort_q <= timeout_hit;
        end
    end

    assign m_sync_reset = sync_reset | abort_q;
`else
    assign timeout_hit  = 1'b0;
    assign m_sync_reset = sync_reset;
`endif

    // Next-state, byte capture and status bookkeeping.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        count_d    = count_q;
        q_cnt_d    = q_cnt_q;
        byte_cnt_d = byte_cnt_q;
        rd_data_d  = rd_data_q;
        rd_index_d = rd_index_q;
        rd_valid_d = 1'b0;
        error_d    = error_q;

        // Bytes are accepted in every burst state, including the final
        // one that arrives alongside (or after) the read request drop.
        if (in_burst && m_data_valid) begin
            rd_data_d  = m_data_out;
            rd_index_d = byte_cnt_q;
            byte_cnt_d = byte_cnt_q + 3'd1;
            rd_valid_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d     = reg_addr;
                    count_d    = clamp_count(byte_count, MAX_BYTES);
                    q_cnt_d    = 4'd0;
                    byte_cnt_d = 3'd0;
                    error_d    = 1'b0;
                    state_d    = ST_WR_PTR;
                end
            end
            ST_WR_PTR: begin
                if (m_nack) begin
                    error_d = 1'b1;
                    state_d = m_stop ? ST_FINISH : ST_WAIT_STOP;
                end else if (m_queued) begin
                    state_d = ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                if (m_nack) begin
                    error_d = 1'b1;
                    state_d = m_stop ? ST_FINISH : ST_WAIT_STOP;
                end else if (m_queued) begin
                    q_cnt_d = q_cnt_q + 4'd1;
                    // Releasing the request now makes the master NACK this byte.
                    if (q_cnt_q + 4'd1 == count_q) begin
                        state_d = ST_RD_LAST;
                    end
                end
            end
            ST_RD_LAST: begin
                if (m_nack) begin
                    error_d = 1'b1;
                    state_d = m_stop ? ST_FINISH : ST_WAIT_STOP;
                end else if (m_stop) begin
                    state_d = ST_FINISH;
                end
            end
            ST_WAIT_STOP: begin
                if (m_nack) begin
                    error_d = 1'b1;
                end
                if (m_stop) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (timeout_hit) begin
            error_d = 1'b1;
            state_d = ST_FINISH;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= 8'd0;
            count_q    <= 4'd0;
            q_cnt_q    <= 4'd0;
            byte_cnt_q <= 3'd0;
            rd_data_q  <= 8'd0;
            rd_index_q <= 3'd0;
            rd_valid_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            q_cnt_q    <= q_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            rd_data_q  <= rd_data_d;
            rd_index_q <= rd_index_d;
            rd_valid_q <= rd_valid_d;
            error_q    <= error_d;
        end
    end

    assign busy           = (state_q != ST_IDLE);
    assign done           = (state_q == ST_FINISH);
    assign error          = error_q;
    assign rd_data        = rd_data_q;
    assign rd_index       = rd_index_q;
    assign rd_valid       = rd_valid_q;
    assign m_data_in      = addr_q;
    assign m_write_enable = (state_q == ST_WR_PTR);
    assign m_read_enable  = (state_q == ST_RD_REQ);

endmodule

// File: tb/tb_i2c_burst_reader.sv
// Bench for i2c_burst_reader: a strobe-level model of the I2C master plus
// sensor at DEVICE_ADDRESS answers the reader's requests with random timing;
// expected bytes, indices, counts and status come from the burst rules.
module tb_i2c_burst_reader;
    import i2c_pkg::*;

    localparam int CLK_DIV = 4;
    localparam int MAXB    = 8;

    logic       clk = 1'b0;
    logic       sync_reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] reg_addr = 8'd0;
    logic [3:0] byte_count = 4'd0;
    logic       busy, done, error, rd_valid, internal_clk;
    logic [7:0] rd_data, m_data_in;
    logic [2:0] rd_index;
    logic       m_write_enable, m_read_enable, m_sync_reset;
    logic       m_queued = 1'b0, m_data_valid = 1'b0, m_nack = 1'b0, m_stop = 1'b0;
    logic [7:0] m_data_out = 8'd0;

    int checks = 0;
    int errors = 0;

    // Master/slave model state
    int         phase = 0, dly = 0, r_idx = 0, rd_q_cnt = 0;
    bit         slave_nack = 0, coincide = 0, hang = 0;
    logic [7:0] sdata [16];

    // Monitor state
    logic [10:0] ev_q[$];
    logic [7:0]  exp_addr = 8'd0;
    int          bad_addr = 0, both_en = 0, bad_nack = 0;
    logic        nack_edge = 1'b0;

    i2c_burst_reader #(.CLK_DIV(CLK_DIV), .MAX_BYTES(MAXB)) dut (
        .clk(clk), .sync_reset(sync_reset), .start(start), .reg_addr(reg_addr),
        .byte_count(byte_count), .busy(busy), .done(done), .error(error),
        .rd_data(rd_data), .rd_index(rd_index), .rd_valid(rd_valid),
        .internal_clk(internal_clk), .m_data_in(m_data_in),
        .m_write_enable(m_write_enable), .m_read_enable(m_read_enable),
        .m_sync_reset(m_sync_reset), .m_queued(m_queued), .m_data_valid(m_data_valid),
        .m_nack(m_nack), .m_stop(m_stop), .m_data_out(m_data_out)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Master + sensor model: reacts to the reader's requests with random delays.
    initial forever begin
        @(negedge clk);
        m_queued = 1'b0; m_data_valid = 1'b0; m_nack = 1'b0; m_stop = 1'b0;
        if (m_sync_reset) begin
            phase = 0;
        end else begin
            case (phase)
                0: if (m_write_enable && !hang) begin
                       dly = $urandom_range(0, 3); r_idx = 0; rd_q_cnt = 0; phase = 1;
                   end
                1: if (dly > 0) dly--;
                   else if (slave_nack) begin
                       m_nack = 1'b1; dly = $urandom_range(0, 3); phase = 4;
                   end else begin
                       m_queued = 1'b1; phase = 2;
                   end
                2: if (m_read_enable) begin dly = $urandom_range(0, 3); phase = 5; end
                5: if (dly > 0) dly--;
                   else begin
                       m_queued = 1'b1; rd_q_cnt++; dly = $urandom_range(0, 2); phase = 3;
                   end
                3: if (dly > 0) dly--;
                   else begin
                       m_data_valid = 1'b1; m_data_out = sdata[r_idx]; r_idx++;
                       if (m_read_enable) begin dly = $urandom_range(0, 3); phase = 5; end
                       else if (coincide) begin m_stop = 1'b1; phase = 0; end
                       else begin dly = $urandom_range(0, 3); phase = 4; end
                   end
                4: if (dly > 0) dly--;
                   else begin m_stop = 1'b1; phase = 0; end
                default: phase = 0;
            endcase
        end
    end

    // Slave NACK as seen by the DUT at the clock edge.
    initial forever begin
        @(posedge clk);
        nack_edge = m_nack;
    end

    // Output monitor: collects rd strobes and watches request-side rules.
    initial forever begin
        @(negedge clk);
        if (rd_valid) ev_q.push_back({rd_index, rd_data});
        if (m_write_enable && (m_data_in !== exp_addr)) bad_addr++;
        if (m_write_enable && m_read_enable) both_en++;
        if (nack_edge && (m_write_enable || m_read_enable)) bad_nack++;
    end

    task automatic run_burst(input string name, input logic [7:0] a, input logic [3:0] bc,
                             input bit nk, input bit co, input bit poke);
        int n;
        int cyc;
        bit got;
        n = (bc == 4'd0) ? 1 : ((int'(bc) > MAXB) ? MAXB : int'(bc));
        slave_nack = nk; coincide = co; exp_addr = a;
        ev_q.delete(); bad_addr = 0; both_en = 0; bad_nack = 0;
        @(negedge clk);
        reg_addr = a; byte_count = bc; start = 1'b1;
        @(negedge clk);
        start = 1'b0; reg_addr = ~a; byte_count = 4'($urandom_range(0, 15));
        chk({name, "/busy"}, 32'(busy), 32'd1);
        cyc = 0;
        while (cyc < 3000) begin
            if (done) break;
            start = (poke && cyc == 5);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        got = done;
        chk({name, "/done_seen"}, 32'(got), 32'd1);
        chk({name, "/error"}, 32'(error), 32'(nk));
        @(negedge clk);
        chk({name, "/done_one_cycle"}, 32'(done), 32'd0);
        chk({name, "/idle_after"}, 32'(busy), 32'd0);
        chk({name, "/error_hold"}, 32'(error), 32'(nk));
        chk({name, "/num_bytes"}, 32'(ev_q.size()), nk ? 32'd0 : 32'(n));
        if (!nk) begin
            for (int i = 0; i < n && i < ev_q.size(); i++) begin
                chk({name, $sformatf("/idx%0d", i)}, 32'(ev_q[i][10:8]), 32'(i % 8));
                chk({name, $sformatf("/data%0d", i)}, 32'(ev_q[i][7:0]), 32'(sdata[i]));
            end
            chk({name, "/read_requests"}, 32'(rd_q_cnt), 32'(n));
        end
        chk({name, "/ptr_byte"}, 32'(bad_addr), 32'd0);
        chk({name, "/one_request"}, 32'(both_en), 32'd0);
        chk({name, "/drop_on_nack"}, 32'(bad_nack), 32'd0);
        $display("burst %s dev=0x%02h reg=0x%02h req=%0d bytes=%0d error=%0b",
                 name, DEVICE_ADDRESS, a, bc, ev_q.size(), error);
    endtask

    initial begin
        int pos[$];
        int cyc;
        logic [7:0] ra;
        logic [3:0] rb;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst/busy", 32'(busy), 32'd0);
        chk("rst/done", 32'(done), 32'd0);
        chk("rst/error", 32'(error), 32'd0);
        chk("rst/rd_valid", 32'(rd_valid), 32'd0);
        chk("rst/rd_data", 32'(rd_data), 32'd0);
        chk("rst/rd_index", 32'(rd_index), 32'd0);
        chk("rst/enables", 32'({m_write_enable, m_read_enable}), 32'd0);
        chk("rst/tick", 32'(internal_clk), 32'd0);
        chk("rst/m_sync_reset", 32'(m_sync_reset), 32'd1);
        @(negedge clk);
        sync_reset = 1'b0;
        #1;
        chk("run/m_sync_reset", 32'(m_sync_reset), 32'd0);

        // Tick divider period
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            if (internal_clk) pos.push_back(i);
        end
        chk("tick/count", 32'(pos.size()), 32'd4);
        for (int i = 1; i < pos.size(); i++)
            chk($sformatf("tick/gap%0d", i), 32'(pos[i] - pos[i-1]), 32'(CLK_DIV));

        // Six-byte burst from 0x3B
        for (int i = 0; i < 16; i++) sdata[i] = 8'h10 + 8'(i);
        run_burst("burst6", 8'h3B, 4'd6, 0, 0, 0);

        // Single byte WHO_AM_I
        sdata[0] = 8'h68;
        run_burst("whoami", 8'h75, 4'd1, 0, 0, 0);

        // Address NACK
        run_burst("nack", 8'h3B, 4'd4, 1, 0, 0);

        // Clamp boundaries
        for (int i = 0; i < 16; i++) sdata[i] = 8'($urandom);
        run_burst("count0", 8'h10, 4'd0, 0, 0, 0);
        for (int i = 0; i < 16; i++) sdata[i] = 8'($urandom);
        run_burst("count15", 8'h20, 4'd15, 0, 1, 0);
        for (int i = 0; i < 16; i++) sdata[i] = 8'($urandom);
        run_burst("count8", 8'h30, 4'd8, 0, 0, 0);

        // Start while busy is ignored
        for (int i = 0; i < 16; i++) sdata[i] = 8'($urandom);
        run_burst("busy_start", 8'h44, 4'd3, 0, 0, 1);

        // Random bursts
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 16; i++) sdata[i] = 8'($urandom);
            ra = 8'($urandom);
            rb = 4'($urandom_range(0, 15));
            run_burst($sformatf("rand%0d", t), ra, rb, 0, bit'($urandom_range(0, 1)), 0);
        end

        // Reset in the middle of byte 2
        for (int i = 0; i < 16; i++) sdata[i] = 8'($urandom);
        slave_nack = 0; coincide = 0; exp_addr = 8'h42; ev_q.delete();
        @(negedge clk);
        reg_addr = 8'h42; byte_count = 4'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (ev_q.size() < 2 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk("midrst/reached_byte2", 32'(ev_q.size()), 32'd2);
        sync_reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst/busy", 32'(busy), 32'd0);
        chk("midrst/enables", 32'({m_write_enable, m_read_enable}), 32'd0);
        chk("midrst/m_sync_reset", 32'(m_sync_reset), 32'd1);
        chk("midrst/rd_data", 32'(rd_data), 32'd0);
        chk("midrst/done", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        sync_reset = 1'b0;
        $display("burst midrst reg=0x42 aborted after %0d bytes", ev_q.size());
        for (int i = 0; i < 16; i++) sdata[i] = 8'($urandom);
        run_burst("post_rst", 8'h3B, 4'd6, 0, 0, 0);

`ifdef I2C_BURST_TIMEOUT_EN
        // Stuck bus: watchdog abort
        hang = 1; ev_q.delete();
        @(negedge clk);
        reg_addr = 8'h3B; byte_count = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (cyc < 70000) begin
            if (done) break;
            start = (cyc == 100);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("timeout/done_seen", 32'(done), 32'd1);
        chk("timeout/error", 32'(error), 32'd1);
        chk("timeout/m_sync_reset", 32'(m_sync_reset), 32'd1);
        chk("timeout/latency", 32'(cyc >= 65535 && cyc <= 65540), 32'd1);
        @(negedge clk);
        chk("timeout/idle", 32'(busy), 32'd0);
        chk("timeout/pulse_end", 32'(m_sync_reset), 32'd0);
        chk("timeout/no_bytes", 32'(ev_q.size()), 32'd0);
        $display("burst timeout reg=0x3B cycles=%0d", cyc);
        hang = 0;
        for (int i = 0; i < 16; i++) sdata[i] = 8'($urandom);
        run_burst("post_timeout", 8'h3B, 4'd2, 0, 0, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
